// File: rtl/morse_pkg.sv
// Shared definitions for the morse trainer: symbol codes, symbolizer FSM states and the
// default timing constants also used by the answer-checking FSM.
package morse_pkg;

  typedef enum logic [1:0] {
    SYM_DOT      = 2'b00,
    SYM_DASH     = 2'b01,
    SYM_CHAR_END = 2'b10,
    SYM_TIMEOUT  = 2'b11
  } sym_code_e;

  typedef enum logic [1:0] {
    StIdle,
    StPress,
    StGap,
    StStuck
  } sym_state_e;

  localparam int unsigned DEF_DOT_MIN  = 20;
  localparam int unsigned DEF_DASH_MIN = 60;
  localparam int unsigned DEF_CHAR_GAP = 40;

endpackage

// File: rtl/morse_debounce.sv
// Two-flop synchroniser followed by a debounce counter.
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   key_i        raw asynchronous key (1 = pressed)
//   key_level_o  debounced level; follows the synced key after it has differed for
//                DEBOUNCE_CYC consecutive cycles (2+DEBOUNCE_CYC cycles from a key_i edge)
module morse_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_i,
  output logic key_level_o
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYC - 1);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Counter holds the number of consecutive cycles the synced key has disagreed with the level.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CntLast) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign key_level_o = level_q;

endmodule

// File: rtl/morse_key_symbolizer.sv
// Turns the raw morse key into symbol events (DOT, DASH, CHAR_END, TIMEOUT) held in a
// 1-deep valid/ready output register.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   enable_i      1 = run; 0 = synchronous clear (FSM, timer, event, count, overrun)
//   key_i         raw key input
//   key_level_o   debounced key level
//   sym_valid_o   event pending; accepted when sym_valid_o & sym_ready_i
//   sym_ready_i   consumer ready
//   sym_code_o    event code (morse_pkg::sym_code_e)
//   sym_cnt_o     DOT/DASH count since last CHAR_END, saturating at 7
//   overrun_o     sticky: an event was dropped because the register was full
module morse_key_symbolizer
  import morse_pkg::*;
#(
  parameter int unsigned CNT_W        = 6,
  parameter int unsigned DEBOUNCE_CYC = 3,
  parameter int unsigned DOT_MIN      = DEF_DOT_MIN,
  parameter int unsigned DASH_MIN     = DEF_DASH_MIN,
  parameter int unsigned CHAR_GAP     = DEF_CHAR_GAP
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable_i,
  input  logic       key_i,
  output logic       key_level_o,
  output logic       sym_valid_o,
  input  logic       sym_ready_i,
  output logic [1:0] sym_code_o,
  output logic [2:0] sym_cnt_o,
  output logic       overrun_o
);

  localparam logic [CNT_W-1:0] DotMinT   = CNT_W'(DOT_MIN);
  localparam logic [CNT_W-1:0] DashMinT  = CNT_W'(DASH_MIN);
  localparam logic [CNT_W-1:0] CharGapT  = CNT_W'(CHAR_GAP);
  localparam logic [CNT_W-1:0] TimerMax  = '1;

  logic             level, level_prev_q, rise, fall;
  sym_state_e       state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             valid_q, valid_d;
  sym_code_e        code_q, code_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             ovr_q, ovr_d;
  logic             emit;
  sym_code_e        emit_code;

  morse_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_debounce (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_i      (key_i),
    .key_level_o(level)
  );

  // Edges are taken against the previous debounced level, which keeps tracking while disabled,
  // so a key already held at re-enable produces no rising edge.
  assign rise = level & ~level_prev_q;
  assign fall = ~level & level_prev_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    emit      = 1'b0;
    emit_code = SYM_DOT;

    case (state_q)
      StIdle: begin
        if (rise) state_d = StPress;
      end
      StPress: begin
        if (fall) begin
          if (timer_q >= DashMinT) begin
            emit      = 1'b1;
            emit_code = SYM_DASH;
          end else if (timer_q >= DotMinT) begin
            emit      = 1'b1;
            emit_code = SYM_DOT;
          end
          // Count even if the event is dropped by a full output register.
          if (emit && cnt_q != 3'd7) cnt_d = cnt_q + 3'd1;
          state_d = (cnt_d != 3'd0) ? StGap : StIdle;
        end else if (timer_q == TimerMax) begin
          emit      = 1'b1;
          emit_code = SYM_TIMEOUT;
          state_d   = StStuck;
        end
      end
      StStuck: begin
        if (fall) begin
          cnt_d   = 3'd0;
          state_d = StIdle;
        end
      end
      StGap: begin
        if (rise) begin
          state_d = StPress;
        end else if (timer_q == CharGapT && !level) begin
          emit      = 1'b1;
          emit_code = SYM_CHAR_END;
          cnt_d     = 3'd0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Timer restarts at 1 on every state change and saturates instead of wrapping.
    if (state_d != state_q) begin
      timer_d = CNT_W'(1);
    end else if (timer_q == TimerMax) begin
      timer_d = timer_q;
    end else begin
      timer_d = timer_q + CNT_W'(1);
    end

    if (!enable_i) begin
      state_d = StIdle;
      timer_d = '0;
      cnt_d   = 3'd0;
      emit    = 1'b0;
    end
  end

  // Output event register.
  always_comb begin
    valid_d = valid_q;
    code_d  = code_q;
    ovr_d   = ovr_q;
    if (valid_q && sym_ready_i) valid_d = 1'b0;
    if (emit) begin
      if (!valid_q || sym_ready_i) begin
        valid_d = 1'b1;
        code_d  = emit_code;
      end else begin
        ovr_d = 1'b1;
      end
    end
    if (!enable_i) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_prev_q <= 1'b0;
      state_q      <= StIdle;
      timer_q      <= '0;
      valid_q      <= 1'b0;
      code_q       <= SYM_DOT;
      cnt_q        <= 3'd0;
      ovr_q        <= 1'b0;
    end else begin
      level_prev_q <= level;
      state_q      <= state_d;
      timer_q      <= timer_d;
      valid_q      <= valid_d;
      code_q       <= code_d;
      cnt_q        <= cnt_d;
      ovr_q        <= ovr_d;
    end
  end

  assign key_level_o = level;
  assign sym_valid_o = valid_q;
  assign sym_code_o  = code_q;
  assign sym_cnt_o   = cnt_q;
  assign overrun_o   = ovr_q;

endmodule

// File: tb/tb_morse_key_symbolizer.sv
module tb_morse_key_symbolizer;

  localparam int unsigned CNT_W    = 6;
  localparam int unsigned DOT_MIN  = 20;
  localparam int unsigned DASH_MIN = 60;
  localparam int unsigned CHAR_GAP = 40;
  localparam int TIMEOUT_LEN = 1 << CNT_W;  // press length at which the timer saturates high

  logic       clk = 1'b0;
  logic       rst_n, enable_i, key_i, sym_ready_i;
  logic       key_level_o, sym_valid_o, overrun_o;
  logic [1:0] sym_code_o;
  logic [2:0] sym_cnt_o;

  always #5 clk = ~clk;

  morse_key_symbolizer #(
    .CNT_W       (CNT_W),
    .DEBOUNCE_CYC(2),
    .DOT_MIN     (DOT_MIN),
    .DASH_MIN    (DASH_MIN),
    .CHAR_GAP    (CHAR_GAP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable_i   (enable_i),
    .key_i      (key_i),
    .key_level_o(key_level_o),
    .sym_valid_o(sym_valid_o),
    .sym_ready_i(sym_ready_i),
    .sym_code_o (sym_code_o),
    .sym_cnt_o  (sym_cnt_o),
    .overrun_o  (overrun_o)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int got_code[$];
  int got_cyc[$];
  int exp_code[$];
  int rise_cyc = 0;
  int fall_cyc = 0;
  bit level_seen = 1'b0;
  logic lvl_prev = 1'b0;

  // Reference model state: symbols in the current character.
  int m_cnt = 0;
  bit m_in_char = 1'b0;

  // Observer: accepted events and debounced edge times, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (rst_n && sym_valid_o && sym_ready_i) begin
      got_code.push_back(int'(sym_code_o));
      got_cyc.push_back(cyc);
    end
    if (key_level_o === 1'b1 && lvl_prev === 1'b0) rise_cyc = cyc;
    if (key_level_o === 1'b0 && lvl_prev === 1'b1) fall_cyc = cyc;
    if (key_level_o === 1'b1) level_seen = 1'b1;
    lvl_prev = key_level_o;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: a debounced press of n cycles, classified by its length.
  function automatic void model_press(input int n);
    if (n >= TIMEOUT_LEN) begin
      exp_code.push_back(3);
      m_cnt = 0;
    end else if (n >= DASH_MIN) begin
      exp_code.push_back(1);
      if (m_cnt < 7) m_cnt++;
    end else if (n >= DOT_MIN) begin
      exp_code.push_back(0);
      if (m_cnt < 7) m_cnt++;
    end
    m_in_char = (m_cnt > 0);
  endfunction

  // Model: a low gap of n cycles ends an open character once it exceeds CHAR_GAP.
  function automatic void model_gap(input int n);
    if (m_in_char && n > CHAR_GAP) begin
      exp_code.push_back(2);
      m_cnt = 0;
      m_in_char = 1'b0;
    end
  endfunction

  task automatic press(input int n);
    key_i = 1'b1;
    tick(n);
    key_i = 1'b0;
    model_press(n);
  endtask

  // Gap of n >= 10 cycles; the symbol count is checked once the preceding press has settled.
  task automatic gap(input string tag, input int n);
    key_i = 1'b0;
    tick(8);
    check({tag, "_cnt"}, 32'(sym_cnt_o), 32'(m_cnt));
    tick(n - 8);
    model_gap(n);
  endtask

  task automatic compare_events(input string tag);
    check({tag, "_nevents"}, 32'(got_code.size()), 32'(exp_code.size()));
    for (int i = 0; i < got_code.size() && i < exp_code.size(); i++) begin
      check($sformatf("%s_ev%0d", tag, i), 32'(got_code[i]), 32'(exp_code[i]));
    end
    got_code.delete();
    got_cyc.delete();
    exp_code.delete();
  endtask

  task automatic model_clear();
    m_cnt = 0;
    m_in_char = 1'b0;
    exp_code.delete();
    got_code.delete();
    got_cyc.delete();
  endtask

  initial begin
    int len, g;
    rst_n = 1'b0;
    enable_i = 1'b1;
    key_i = 1'b0;
    sym_ready_i = 1'b1;
    tick(3);
    check("rst_level", 32'(key_level_o), 0);
    check("rst_valid", 32'(sym_valid_o), 0);
    check("rst_code", 32'(sym_code_o), 0);
    check("rst_cnt", 32'(sym_cnt_o), 0);
    check("rst_ovr", 32'(overrun_o), 0);
    rst_n = 1'b1;
    tick(2);

    // 1: single DOT, debounce latency, event timing relative to the debounced fall.
    key_i = 1'b1;
    tick(3);
    check("lat_before", 32'(key_level_o), 0);
    tick(1);
    check("lat_at", 32'(key_level_o), 1);
    tick(26);
    key_i = 1'b0;
    model_press(30);
    gap("t1", 60);
    if (got_cyc.size() >= 2) begin
      check("t1_dot_delay", 32'(got_cyc[0] - fall_cyc), 1);
      check("t1_char_end_delay", 32'(got_cyc[1] - fall_cyc), 32'(CHAR_GAP + 1));
    end
    compare_events("t1");
    check("t1_cnt_end", 32'(sym_cnt_o), 0);

    // 2: DASH, DOT, CHAR_END (62 stays below the 64-cycle saturation that would mean TIMEOUT).
    press(62);
    gap("t2a", 10);
    press(25);
    gap("t2b", 50);
    compare_events("t2");

    // Classification and gap boundaries.
    press(19);
    gap("bnd_a", 20);
    press(20);
    gap("bnd_b", 40);
    press(59);
    gap("bnd_c", 41);
    press(60);
    gap("bnd_d", 41);
    press(63);
    gap("bnd_e", 41);
    press(64);
    gap("bnd_f", 20);
    compare_events("bnd");

    // 3: glitch from IDLE.
    press(10);
    gap("t3", 50);
    compare_events("t3");
    check("t3_cnt", 32'(sym_cnt_o), 0);

    // 4: 1-cycle pulses never pass the debouncer.
    level_seen = 1'b0;
    repeat (17) begin
      key_i = 1'b1;
      tick(1);
      key_i = 1'b0;
      tick(2);
    end
    tick(10);
    check("t4_level", 32'(level_seen), 0);
    compare_events("t4");

    // Symbol count saturation.
    repeat (8) begin
      press(25);
      gap("sat", 12);
    end
    gap("sat_end", 60);
    compare_events("sat");

    // Randomized presses and gaps against the model.
    repeat (16) begin
      case ($urandom_range(0, 4))
        0: len = int'($urandom_range(3, DOT_MIN - 1));
        1, 2: len = int'($urandom_range(DOT_MIN, DASH_MIN - 1));
        3: len = int'($urandom_range(DASH_MIN, TIMEOUT_LEN - 1));
        default: len = int'($urandom_range(TIMEOUT_LEN, TIMEOUT_LEN + 20));
      endcase
      g = ($urandom_range(0, 2) == 0) ? int'($urandom_range(CHAR_GAP + 1, 60))
                                      : int'($urandom_range(10, CHAR_GAP));
      press(len);
      gap("rnd", g);
    end
    gap("rnd_end", 60);
    compare_events("rnd");

    // 5: full register holds DOT, DASH dropped, enable clear.
    sym_ready_i = 1'b0;
    press(30);
    gap("t5a", 10);
    press(62);
    gap("t5b", 10);
    check("t5_valid", 32'(sym_valid_o), 1);
    check("t5_code", 32'(sym_code_o), 0);
    check("t5_ovr", 32'(overrun_o), 1);
    enable_i = 1'b0;
    tick(1);
    enable_i = 1'b1;
    check("t5_clr_valid", 32'(sym_valid_o), 0);
    check("t5_clr_ovr", 32'(overrun_o), 0);
    check("t5_clr_cnt", 32'(sym_cnt_o), 0);
    model_clear();
    sym_ready_i = 1'b1;
    tick(50);
    compare_events("t5_after");

    // Re-enable with the key already held: no event.
    enable_i = 1'b0;
    key_i = 1'b1;
    tick(10);
    enable_i = 1'b1;
    tick(30);
    key_i = 1'b0;
    tick(60);
    compare_events("reen");
    check("reen_cnt", 32'(sym_cnt_o), 0);

    // 6: held key gives one TIMEOUT, then nothing.
    key_i = 1'b1;
    tick(100);
    key_i = 1'b0;
    model_press(100);
    if (got_cyc.size() >= 1) begin
      check("t6_timeout_delay", 32'(got_cyc[0] - rise_cyc), 32'(TIMEOUT_LEN));
    end
    gap("t6", 50);
    compare_events("t6");

    // Reset mid-press with an event pending.
    sym_ready_i = 1'b0;
    press(30);
    gap("t6r", 10);
    key_i = 1'b1;
    tick(30);
    rst_n = 1'b0;
    #1;
    check("rstmid_level", 32'(key_level_o), 0);
    check("rstmid_valid", 32'(sym_valid_o), 0);
    check("rstmid_code", 32'(sym_code_o), 0);
    check("rstmid_cnt", 32'(sym_cnt_o), 0);
    check("rstmid_ovr", 32'(overrun_o), 0);
    tick(2);
    key_i = 1'b0;
    rst_n = 1'b1;
    model_clear();
    sym_ready_i = 1'b1;
    tick(20);
    check("rstmid_after_valid", 32'(sym_valid_o), 0);
    compare_events("rstmid");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
